// File: rtl/bc_input_pkg.sv
// Shared types and digit-validation helper for the guess input path.
package bc_input_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    HOLD   = 2'd2,
    REJECT = 2'd3
  } input_state_t;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    BAD_DIGIT = 2'd1,
    REPEAT    = 2'd2
  } reject_code_t;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned GUESS_W    = NUM_DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  // Non-decimal digits outrank repeated digits when both are present.
  function automatic reject_code_t classify_guess(input logic [GUESS_W-1:0] v);
    logic bad;
    logic rep;
    bad = 1'b0;
    rep = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT) bad = 1'b1;
      for (int unsigned j = i + 1; j < NUM_DIGITS; j++) begin
        if (v[i*DIGIT_W +: DIGIT_W] == v[j*DIGIT_W +: DIGIT_W]) rep = 1'b1;
      end
    end
    if (bad)      return BAD_DIGIT;
    else if (rep) return REPEAT;
    else          return NONE;
  endfunction

endpackage

// File: rtl/guess_input_ctrl_if.sv
// Guess handshake and status bundle between the input controller and the game core.
interface guess_input_ctrl_if;
  import bc_input_pkg::*;

  logic               guess_ready;
  logic               guess_valid;
  logic [GUESS_W-1:0] guess;
  logic               reject;
  reject_code_t       reject_code;
  logic               busy;

  modport master (
    input  guess_ready,
    output guess_valid, guess, reject, reject_code, busy
  );

  modport slave (
    output guess_ready,
    input  guess_valid, guess, reject, reject_code, busy
  );
endinterface

// File: rtl/debouncer.sv
// Two-flop synchronizer plus counter debouncer; emits a one-cycle pulse on each accepted rising level.
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/guess_input_ctrl.sv
// Turns switches plus a debounced confirm press into validated guess transactions or reject pulses.
module guess_input_ctrl
  import bc_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [GUESS_W-1:0] sw,
  input  logic               confirm_raw,
  guess_input_ctrl_if.master gio
);

  input_state_t       state_q, state_d;
  logic [GUESS_W-1:0] sw_s1_q, sw_s2_q;
  logic [GUESS_W-1:0] snap_q;
  logic [GUESS_W-1:0] guess_q;
  reject_code_t       code_q;
  reject_code_t       chk_code;
  logic               press;

  debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_confirm_deb (
    .clk_i  (clock),
    .rst_i  (reset),
    .raw_i  (confirm_raw),
    .rise_o (press)
  );

  assign chk_code = classify_guess(snap_q);

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Presses outside IDLE are simply not looked at, so they are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (press) state_d = CHECK;
      CHECK:   state_d = (chk_code == NONE) ? HOLD : REJECT;
      HOLD:    if (gio.guess_ready) state_d = IDLE;
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      snap_q  <= '0;
      guess_q <= '0;
      code_q  <= NONE;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
      if (state_q == IDLE && press) snap_q <= sw_s2_q;
      if (state_q == CHECK) begin
        if (chk_code == NONE) guess_q <= snap_q;
        else                  code_q  <= chk_code;
      end
    end
  end

  always_comb begin
    gio.guess_valid = (state_q == HOLD);
    gio.reject      = (state_q == REJECT);
    gio.busy        = (state_q == CHECK) || (state_q == HOLD);
    gio.guess       = guess_q;
    gio.reject_code = code_q;
  end

endmodule

// File: tb/tb_guess_input_ctrl.sv
// Scoreboard bench for guess_input_ctrl with a short debounce window.
module tb_guess_input_ctrl;

  logic        clock;
  logic        reset;
  logic [15:0] sw;
  logic        confirm_raw;

  guess_input_ctrl_if gif ();

  guess_input_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sw          (sw),
    .confirm_raw (confirm_raw),
    .gio         (gif.master)
  );

  int total = 0;
  int bad   = 0;
  int valid_cycles  = 0;
  int busy_cycles   = 0;
  int reject_cycles = 0;
  int transfers     = 0;

  logic [15:0] exp_g_q[$];
  logic [1:0]  rej_q[$];
  logic        hold_pend = 1'b0;
  logic [15:0] hold_val  = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: pops expected guesses on transfers and expected codes on reject pulses.
  always @(negedge clock) begin
    logic [15:0] eg;
    logic [1:0]  ec;
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (gif.guess_valid) valid_cycles++;
      if (gif.busy) busy_cycles++;
      if (gif.reject) begin
        reject_cycles++;
        total++;
        if (rej_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_reject got code=%0d want no reject", gif.reject_code);
        end else begin
          ec = rej_q.pop_front();
          if (gif.reject_code !== ec) begin
            bad++;
            $display("FAIL reject_code got=%0d want=%0d", gif.reject_code, ec);
          end
        end
      end
      if (hold_pend) begin
        total++;
        if (gif.guess_valid !== 1'b1 || gif.guess !== hold_val) begin
          bad++;
          $display("FAIL hold_stable got valid=%0b guess=%h want valid=1 guess=%h",
                   gif.guess_valid, gif.guess, hold_val);
        end
      end
      if (gif.guess_valid && gif.guess_ready) begin
        transfers++;
        total++;
        if (exp_g_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_guess got=%h want no transfer", gif.guess);
        end else begin
          eg = exp_g_q.pop_front();
          if (gif.guess !== eg) begin
            bad++;
            $display("FAIL guess_value got=%h want=%h", gif.guess, eg);
          end
        end
      end
      hold_pend = gif.guess_valid && !gif.guess_ready;
      hold_val  = gif.guess;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input int hold);
    confirm_raw = 1'b1;
    cyc(hold);
    confirm_raw = 1'b0;
    cyc(12);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    confirm_raw = 1'b0;
    sw = '0;
    gif.guess_ready = 1'b0;
    cyc(3);
    @(negedge clock);
    total++;
    if (gif.guess_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", gif.guess_valid); end
    total++;
    if (gif.guess !== 16'h0000) begin bad++; $display("FAIL reset_guess got=%h want=0000", gif.guess); end
    total++;
    if (gif.reject !== 1'b0) begin bad++; $display("FAIL reset_reject got=%b want=0", gif.reject); end
    total++;
    if (gif.reject_code !== 2'd0) begin bad++; $display("FAIL reset_code got=%0d want=0", gif.reject_code); end
    total++;
    if (gif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", gif.busy); end
    @(posedge clock); #1;
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_single_pulse;
    int t0, v0, r0;
    logic found;
    gif.guess_ready = 1'b1;
    sw = 16'h1234;
    cyc(3);
    t0 = transfers; v0 = valid_cycles; r0 = reject_cycles;
    exp_g_q.push_back(16'h1234);
    confirm_raw = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clock);
      if (gif.busy) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL single_busy_timeout got busy=0 want busy within 30 cycles");
    end else begin
      total++;
      if (gif.guess_valid !== 1'b0) begin bad++; $display("FAIL single_check_cycle got valid=%b want=0", gif.guess_valid); end
      @(negedge clock);
      total++;
      if (gif.guess_valid !== 1'b1 || gif.guess !== 16'h1234) begin
        bad++;
        $display("FAIL single_latency got valid=%b guess=%h want valid=1 guess=1234", gif.guess_valid, gif.guess);
      end
    end
    cyc(2);
    confirm_raw = 1'b0;
    cyc(14);
    total++;
    if (transfers - t0 !== 1) begin bad++; $display("FAIL single_transfers got=%0d want=1", transfers - t0); end
    total++;
    if (valid_cycles - v0 !== 1) begin bad++; $display("FAIL single_valid_width got=%0d want=1", valid_cycles - v0); end
    total++;
    if (reject_cycles !== r0) begin bad++; $display("FAIL single_no_reject got=%0d want=0", reject_cycles - r0); end
  endtask

  task automatic test_reject;
    logic [15:0] vals [3];
    logic [1:0]  codes[3];
    int v0, r0;
    vals  = '{16'h1A23, 16'h1123, 16'hAA00};
    codes = '{2'd1, 2'd2, 2'd1};
    gif.guess_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sw = vals[k];
      cyc(3);
      v0 = valid_cycles; r0 = reject_cycles;
      rej_q.push_back(codes[k]);
      press(8);
      total++;
      if (reject_cycles - r0 !== 1) begin bad++; $display("FAIL reject_width sw=%h got=%0d want=1", vals[k], reject_cycles - r0); end
      total++;
      if (valid_cycles !== v0) begin bad++; $display("FAIL reject_no_valid sw=%h got=%0d want=0", vals[k], valid_cycles - v0); end
      total++;
      if (gif.reject_code !== codes[k]) begin bad++; $display("FAIL reject_code_held sw=%h got=%0d want=%0d", vals[k], gif.reject_code, codes[k]); end
    end
  endtask

  task automatic test_busy_drop;
    int t0;
    logic found;
    gif.guess_ready = 1'b0;
    sw = 16'h5678;
    cyc(3);
    t0 = transfers;
    exp_g_q.push_back(16'h5678);
    confirm_raw = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clock);
      if (gif.guess_valid) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL drop_valid_timeout got valid=0 want valid within 30 cycles"); end
    cyc(4);
    confirm_raw = 1'b0;
    cyc(12);
    sw = 16'h9012;
    cyc(3);
    press(8);
    total++;
    if (gif.guess !== 16'h5678) begin bad++; $display("FAIL drop_guess_held got=%h want=5678", gif.guess); end
    total++;
    if (gif.busy !== 1'b1 || gif.guess_valid !== 1'b1) begin
      bad++;
      $display("FAIL drop_busy got busy=%b valid=%b want busy=1 valid=1", gif.busy, gif.guess_valid);
    end
    total++;
    if (transfers !== t0) begin bad++; $display("FAIL drop_early_transfer got=%0d want=0", transfers - t0); end
    gif.guess_ready = 1'b1;
    cyc(3);
    total++;
    if (transfers - t0 !== 1) begin bad++; $display("FAIL drop_transfer got=%0d want=1", transfers - t0); end
    total++;
    if (gif.guess_valid !== 1'b0 || gif.busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle got valid=%b busy=%b want 0 0", gif.guess_valid, gif.busy);
    end
    total++;
    if (gif.guess !== 16'h5678) begin bad++; $display("FAIL drop_guess_kept got=%h want=5678", gif.guess); end
    cyc(20);
    total++;
    if (transfers - t0 !== 1) begin bad++; $display("FAIL drop_no_second got=%0d want=1", transfers - t0); end
  endtask

  task automatic test_glitch;
    int b0, v0, r0;
    gif.guess_ready = 1'b1;
    sw = 16'h1357;
    cyc(3);
    b0 = busy_cycles; v0 = valid_cycles; r0 = reject_cycles;
    for (int i = 0; i < 40; i++) begin
      confirm_raw = ((i / 3) % 2) == 0;
      cyc(1);
    end
    confirm_raw = 1'b0;
    cyc(10);
    total++;
    if (busy_cycles !== b0) begin bad++; $display("FAIL glitch_busy got=%0d want=0", busy_cycles - b0); end
    total++;
    if (valid_cycles !== v0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", valid_cycles - v0); end
    total++;
    if (reject_cycles !== r0) begin bad++; $display("FAIL glitch_reject got=%0d want=0", reject_cycles - r0); end
  endtask

  task automatic test_reset_mid;
    int t0;
    logic found;
    gif.guess_ready = 1'b0;
    sw = 16'h4321;
    cyc(3);
    confirm_raw = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clock);
      if (gif.guess_valid) found = 1'b1;
    end
    total++;
    if (!found || gif.guess !== 16'h4321) begin
      bad++;
      $display("FAIL midreset_hold got valid=%b guess=%h want valid=1 guess=4321", gif.guess_valid, gif.guess);
    end
    @(posedge clock); #1;
    confirm_raw = 1'b0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (gif.guess_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b want=0", gif.guess_valid); end
    total++;
    if (gif.guess !== 16'h0000) begin bad++; $display("FAIL midreset_guess got=%h want=0000", gif.guess); end
    total++;
    if (gif.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", gif.busy); end
    total++;
    if (gif.reject_code !== 2'd0) begin bad++; $display("FAIL midreset_code got=%0d want=0", gif.reject_code); end
    cyc(10);
    gif.guess_ready = 1'b1;
    sw = 16'h0987;
    cyc(3);
    t0 = transfers;
    exp_g_q.push_back(16'h0987);
    press(8);
    total++;
    if (transfers - t0 !== 1) begin bad++; $display("FAIL midreset_after got=%0d want=1", transfers - t0); end
  endtask

  task automatic test_hold_long;
    int t0;
    gif.guess_ready = 1'b1;
    sw = 16'h0123;
    cyc(3);
    t0 = transfers;
    exp_g_q.push_back(16'h0123);
    confirm_raw = 1'b1;
    cyc(200);
    confirm_raw = 1'b0;
    cyc(12);
    total++;
    if (transfers - t0 !== 1) begin bad++; $display("FAIL long_single got=%0d want=1", transfers - t0); end
    exp_g_q.push_back(16'h0123);
    press(8);
    total++;
    if (transfers - t0 !== 2) begin bad++; $display("FAIL long_repress got=%0d want=2", transfers - t0); end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_reject();
    test_busy_drop();
    test_glitch();
    test_reset_mid();
    test_hold_long();
    cyc(5);
    total++;
    if (exp_g_q.size() != 0) begin bad++; $display("FAIL leftover_guesses got=%0d want=0", exp_g_q.size()); end
    total++;
    if (rej_q.size() != 0) begin bad++; $display("FAIL leftover_rejects got=%0d want=0", rej_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/guess_input_ctrl.md
Name: guess_input_ctrl

Overview:
Input-side counterpart of the display path. It converts the raw switch bank and the centre confirm button into clean, validated guess transactions for the bullsCows game core. It synchronizes and debounces the button, snapshots the 16 switches on a confirmed press, and checks that the value is four distinct decimal digits. Legal guesses are handed to the core over a valid/ready handshake; illegal ones are flagged with a one-cycle reject pulse and a reason code.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles confirm must be stable before a level change is accepted (10 ms at 100 MHz); minimum 1.
CNT_W, 20, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
sw  in  16  raw switches; nibble [15:12] = digit 0 (leftmost) ... [3:0] = digit 3
confirm_raw  in  1  raw, asynchronous, bouncing button
guess_ready  in  1  core can accept a guess this cycle
guess_valid  out  1  guess holds a legal, stable value
guess  out  16  captured guess, four BCD nibbles
reject  out  1  one-cycle pulse: press rejected
reject_code  out  2  reason for last reject; held until next reject or reset
busy  out  1  high in CHECK or HOLD; presses are ignored

Behaviour:
- Reset values: guess_valid=0, guess=16'h0000, reject=0, reject_code=NONE(2'd0), busy=0. Synchronizers=0, debounced level=0, counter=0, state=IDLE.
- Synchronization: confirm_raw and sw each pass through a 2-flop synchronizer before any use.
- Debounce:
  - If the synced level equals the debounced level, the counter is cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never flips the level.
- Press event: a one-cycle pulse on the debounced 0->1 edge only. Releases generate nothing.
- FSM states: IDLE, CHECK, HOLD, REJECT.
  - IDLE: on press, capture synced sw into the snapshot register and go to CHECK (cycle N+1).
  - CHECK: evaluate the snapshot.
    - Any nibble > 9: code BAD_DIGIT(2'd1).
    - Otherwise, any two nibbles equal (6 pairwise compares): code REPEAT(2'd2).
    - BAD_DIGIT takes priority over REPEAT.
    - Legal: load guess and go to HOLD, so guess_valid=1 from cycle N+2.
    - Illegal: go to REJECT.
  - HOLD: guess_valid=1 and guess stable until a cycle with guess_ready=1. That cycle completes the transfer; the next cycle is IDLE with guess_valid=0. guess keeps its last value after the transfer.
  - REJECT: reject=1 for exactly one cycle with reject_code updated in the same cycle, then IDLE.
- Latency: press-to-guess_valid is 2 cycles after the debounced edge. If guess_ready is already high, guess_valid lasts exactly 1 cycle.
- Presses while busy: dropped, not queued. Switch changes after capture do not affect guess.
- Simultaneous press and ready in HOLD: the transfer completes and the press is dropped.
- Reset mid-operation (any state, any counter value): returns to IDLE with all outputs at reset values on the next edge. A pending guess is discarded.
- Holding the button down produces one press only; the user must release and re-press.

Decomposition:
- Shared package bc_input_pkg:
  - input_state_t enum {IDLE, CHECK, HOLD, REJECT}
  - reject_code_t {NONE=0, BAD_DIGIT=1, REPEAT=2}
  - localparam NUM_DIGITS=4, DIGIT_W=4, MAX_DIGIT=9
- Sub-module debouncer (params DEBOUNCE_CYCLES, CNT_W): contains the synchronizer, counter, debounced level and rise pulse. It is instantiated once for confirm.
- Switch synchronizer and digit validation stay inline.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
1. sw=16'h1234, confirm held 10 cycles, guess_ready=1 -> a single guess_valid pulse with guess=16'h1234, reject stays 0.
2. sw=16'h1A23, clean press -> reject=1 for 1 cycle, reject_code=1, guess_valid never asserted. Then sw=16'h1123, press -> reject_code=2. Then sw=16'hAA00 -> reject_code=1 (priority check).
3. guess_ready=0, sw=16'h5678, press, then a second press with sw=16'h9012 while in HOLD -> guess stays 16'h5678 and busy=1. Raise ready -> one transfer, IDLE, and 9012 is never presented.
4. confirm toggles with 3-cycle-wide glitches for 40 cycles -> no press, no guess_valid, no reject.
5. reset asserted for 1 cycle during HOLD (guess=16'h4321) -> next cycle guess_valid=0, guess=16'h0000, busy=0. A later press with 16'h0987 is accepted normally.
6. confirm held high for 200 cycles with sw=16'h0123 -> exactly one transaction. After release and re-press, a second transaction occurs.
